// File: rtl/run_ctrl_monitor.sv
// Run control for the rv32i_cpu harness: core reset sequencing,
// halt/timeout detection and per-cycle trace capture into a drainable FIFO.
module run_ctrl_monitor #(
  parameter int RST_CYCLES = 5,
  parameter int CYCLE_W = 32,
  parameter int NUM_HALT = 2,
  parameter logic [NUM_HALT*32-1:0] HALT_PATTERNS =
    {32'h00100073, 32'h00000073},
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CYCLE_W-1:0] max_cycles,
  output logic               cpu_rst,
  input  logic [31:0]        pc_f,
  input  logic [31:0]        instr_f,
  input  logic [31:0]        instr_d,
  input  logic [31:0]        instr_e,
  input  logic [31:0]        result_e,
  input  logic               branch_taken,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [CYCLE_W+160:0] trace_data,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               halted,
  output logic               timed_out,
  output logic               done,
  output logic [15:0]        drop_count
);

  localparam int REC_W  = CYCLE_W + 161;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              push_req;
  logic              cyc_inc;
  logic              set_halt;
  logic              set_to;
  logic              halt_hit;
  logic              timeout_hit;

  logic [REC_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [REC_W-1:0]  record;

  always_comb begin
    halt_hit = 1'b0;
    for (int i = 0; i < NUM_HALT; i++) begin
      if (instr_e == HALT_PATTERNS[32*i +: 32])
        halt_hit = 1'b1;
    end
  end

  assign timeout_hit = (max_cycles != '0) &&
                       (cycle_count >= max_cycles);

  assign record = {cycle_count, pc_f, instr_f, instr_d,
                   instr_e, result_e, branch_taken};

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    push_req = 1'b0;
    cyc_inc  = 1'b0;
    set_halt = 1'b0;
    set_to   = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (hold_q == HOLD_W'(RST_CYCLES))
          state_d = RUN;
        else
          hold_d = hold_q + HOLD_W'(1);
      end
      RUN: begin
        push_req = 1'b1;
        cyc_inc  = 1'b1;
        // halt wins over timeout when both hit together
        if (halt_hit) begin
          set_halt = 1'b1;
          state_d  = DRAIN;
        end else if (timeout_hit) begin
          set_to  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_cnt == '0)
          state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_q      <= '0;
      cpu_rst     <= 1'b1;
      cycle_count <= '0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cpu_rst <= (state_d != RUN);
      if (cyc_inc)
        cycle_count <= cycle_count + CYCLE_W'(1);
      if (set_halt)
        halted <= 1'b1;
      if (set_to)
        timed_out <= 1'b1;
    end
  end

  assign done = (state_q == DONE);

  assign full        = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign trace_valid = (fifo_cnt != '0);
  assign pop         = trace_valid && trace_ready;
  // a full FIFO still accepts when the head leaves this cycle
  assign push        = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;
  assign trace_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= record;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      drop_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_run_ctrl_monitor.sv
// Bench for run_ctrl_monitor: directed scenarios with random core taps,
// checked every cycle against a queue-based reference model.
module tb_run_ctrl_monitor;

  localparam int RST_CYCLES = 5;
  localparam int CW = 32;
  localparam int DEPTH = 8;
  localparam int RW = CW + 161;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] max_cycles = '0;
  logic          cpu_rst;
  logic [31:0]   pc_f = '0;
  logic [31:0]   instr_f = '0;
  logic [31:0]   instr_d = '0;
  logic [31:0]   instr_e = '0;
  logic [31:0]   result_e = '0;
  logic          branch_taken = 1'b0;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [RW-1:0] trace_data;
  logic [CW-1:0] cycle_count;
  logic          halted;
  logic          timed_out;
  logic          done;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  run_ctrl_monitor #(
    .RST_CYCLES(RST_CYCLES),
    .CYCLE_W(CW),
    .NUM_HALT(2),
    .HALT_PATTERNS({32'h00100073, 32'h00000073}),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .max_cycles(max_cycles),
    .cpu_rst(cpu_rst),
    .pc_f(pc_f),
    .instr_f(instr_f),
    .instr_d(instr_d),
    .instr_e(instr_e),
    .result_e(result_e),
    .branch_taken(branch_taken),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_data(trace_data),
    .cycle_count(cycle_count),
    .halted(halted),
    .timed_out(timed_out),
    .done(done),
    .drop_count(drop_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  int            since_rst = 0;
  bit            m_stop = 0;
  bit            m_halt = 0;
  bit            m_to = 0;
  bit            m_done = 0;
  int            m_cyc = 0;
  int            m_drop = 0;
  logic [RW-1:0] q[$];
  int            pops = 0;
  int            last_pop_cyc = -1;

  int            k_max = 0;
  int            k_halt_at = -1;
  logic [31:0]   k_hword = 32'h00000073;
  int            k_ready = 1;
  bit            chk_en = 0;
  logic          last_cpu_rst;

  function automatic bit is_halt(logic [31:0] w);
    return (w == 32'h00000073) || (w == 32'h00100073);
  endfunction

  function automatic bit m_run();
    return (since_rst >= RST_CYCLES + 1) && !m_stop;
  endfunction

  task automatic chk(string tag, logic [RW-1:0] obs,
                     logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("cpu_rst", cpu_rst, !m_run());
    chk("trace_valid", trace_valid, q.size() != 0);
    if (q.size() != 0)
      chk("trace_data", trace_data, q[0]);
    chk("cycle_count", cycle_count, RW'(m_cyc));
    chk("halted", halted, m_halt);
    chk("timed_out", timed_out, m_to);
    chk("done", done, m_done);
    chk("drop_count", drop_count, RW'(m_drop));
  endtask

  task automatic model_step();
    bit pop, run, full;
    logic [RW-1:0] rec;
    if (rst) begin
      since_rst = 0;
      m_stop = 0;
      m_halt = 0;
      m_to = 0;
      m_done = 0;
      m_cyc = 0;
      m_drop = 0;
      pops = 0;
      last_pop_cyc = -1;
      q.delete();
    end else begin
      pop = (q.size() != 0) && trace_ready;
      full = (q.size() == DEPTH);
      run = m_run();
      if (m_stop && !m_done && q.size() == 0)
        m_done = 1;
      if (pop) begin
        last_pop_cyc = int'(q[0][RW-1 -: CW]);
        pops++;
        void'(q.pop_front());
      end
      if (run) begin
        rec = {CW'(m_cyc), pc_f, instr_f, instr_d,
               instr_e, result_e, branch_taken};
        if (!full || pop)
          q.push_back(rec);
        else if (m_drop < 65535)
          m_drop++;
        if (is_halt(instr_e)) begin
          m_halt = 1;
          m_stop = 1;
        end else if (max_cycles != 0 && m_cyc >= int'(max_cycles)) begin
          m_to = 1;
          m_stop = 1;
        end
        m_cyc++;
      end
      since_rst++;
    end
  endtask

  task automatic cycle(input bit r);
    @(negedge clk);
    if (chk_en)
      check_outputs();
    last_cpu_rst = cpu_rst;
    rst = r;
    pc_f = $urandom;
    instr_f = $urandom;
    instr_d = $urandom;
    result_e = $urandom;
    branch_taken = 1'($urandom);
    instr_e = $urandom;
    if (is_halt(instr_e))
      instr_e = instr_e ^ 32'h100;
    // halt words outside RUN must be ignored
    if (!m_run() && $urandom_range(0, 3) == 0)
      instr_e = 32'h00000073;
    if (!r && m_run() && m_cyc == k_halt_at)
      instr_e = k_hword;
    max_cycles = CW'(k_max);
    trace_ready = (k_ready == 2) ? 1'($urandom) : (k_ready != 0);
    model_step();
  endtask

  task automatic wait_hold();
    int n = 0;
    do begin
      cycle(0);
      n += int'(last_cpu_rst === 1'b1);
    end while (last_cpu_rst === 1'b1 && n < 20);
    chk("hold_len", RW'(n), RW'(RST_CYCLES + 1));
  endtask

  task automatic do_reset();
    cycle(1);
    wait_hold();
  endtask

  task automatic run_until_done(input int budget);
    int i = 0;
    while (!m_done && i < budget) begin
      cycle(0);
      i++;
    end
    cycle(0);
    chk("done_end", done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    cycle(1);
    chk_en = 1;

    // halt at cycle 10, free-flowing consumer
    k_max = 0; k_halt_at = 10; k_hword = 32'h00000073; k_ready = 1;
    do_reset();
    run_until_done(200);
    chk("s1_pops", RW'(pops), RW'(11));
    chk("s1_last", RW'(last_pop_cyc), RW'(10));
    chk("s1_halted", halted, 1'b1);
    chk("s1_timed_out", timed_out, 1'b0);
    chk("s1_drops", drop_count, 16'd0);

    // cycle limit
    k_max = 20; k_halt_at = -1; k_ready = 1;
    do_reset();
    run_until_done(200);
    chk("s2_pops", RW'(pops), RW'(21));
    chk("s2_last", RW'(last_pop_cyc), RW'(20));
    chk("s2_timed_out", timed_out, 1'b1);
    chk("s2_halted", halted, 1'b0);
    chk("s2_cpu_rst", cpu_rst, 1'b1);

    // backpressure: FIFO fills, overflow records dropped
    k_max = 0; k_halt_at = 11; k_ready = 0;
    do_reset();
    i = 0;
    while (!m_stop && i < 100) begin
      cycle(0);
      i++;
    end
    repeat (3) cycle(0);
    chk("s3_drops", drop_count, 16'd4);
    chk("s3_valid", trace_valid, 1'b1);
    chk("s3_head", trace_data[RW-1 -: CW], 32'd0);
    k_ready = 1;
    run_until_done(200);
    chk("s3_pops", RW'(pops), RW'(8));
    chk("s3_last", RW'(last_pop_cyc), RW'(7));

    // halt and timeout together
    k_max = 5; k_halt_at = 5; k_hword = 32'h00100073; k_ready = 1;
    do_reset();
    run_until_done(200);
    chk("s4_halted", halted, 1'b1);
    chk("s4_timed_out", timed_out, 1'b0);
    chk("s4_pops", RW'(pops), RW'(6));

    // reset mid-run with records pending
    k_max = 0; k_halt_at = -1; k_ready = 0;
    do_reset();
    i = 0;
    while (!(m_run() && m_cyc == 3) && i < 100) begin
      cycle(0);
      i++;
    end
    cycle(1);
    @(posedge clk);
    #1;
    chk("s5_valid", trace_valid, 1'b0);
    chk("s5_drops", drop_count, 16'd0);
    chk("s5_cpu_rst", cpu_rst, 1'b1);
    k_halt_at = 4; k_ready = 1;
    wait_hold();
    run_until_done(200);
    chk("s5_pops", RW'(pops), RW'(5));

    // randomized runs with random backpressure
    for (int r = 0; r < 4; r++) begin
      k_max = $urandom_range(10, 40);
      k_halt_at = $urandom_range(3, 50);
      k_hword = ($urandom_range(0, 1) != 0) ? 32'h00100073
                                           : 32'h00000073;
      k_ready = 2;
      do_reset();
      run_until_done(400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/run_ctrl_monitor.md
# run_ctrl_monitor

Synthesizable run-control and trace-capture block that sits beside the rv32i_cpu core in the simulation and FPGA harness. It sequences core reset, counts run cycles, and detects halt on a configurable set of retiring system instructions or on a cycle limit. Each run cycle it buffers a trace record of the core debug taps in a FIFO, which drains through a valid/ready port. It generalises the fixed reset length, halt opcodes and cycle limit into parameters and ports, and adds backpressure with drop accounting.

## Interface
Parameters:
- RST_CYCLES, 5: number of clk cycles cpu_rst is held after rst release (≥1).
- CYCLE_W, 32: width of cycle counter and max_cycles.
- NUM_HALT, 2: number of halt instruction patterns.
- HALT_PATTERNS, {32'h00100073, 32'h00000073}: packed NUM_HALT×32; entry i is bits [32i+31:32i].
- FIFO_DEPTH, 8: trace FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- max_cycles  in  CYCLE_W  cycle limit; 0 = unlimited; sampled every cycle.
- cpu_rst  out  1  reset to core, registered.
- pc_f, instr_f, instr_d, instr_e, result_e  in  32 each  core debug taps.
- branch_taken  in  1  core debug tap.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  consumer accepts head record.
- trace_data  out  CYCLE_W+161  head record {cycle, pc_f, instr_f, instr_d, instr_e, result_e, branch_taken}, MSB first.
- cycle_count  out  CYCLE_W  current run cycle index.
- halted  out  1  sticky; stop caused by halt pattern.
- timed_out  out  1  sticky; stop caused by cycle limit.
- done  out  1  stopped and FIFO fully drained.
- drop_count  out  16  saturating count of records lost to full FIFO.

## Operation
- States: HOLD, RUN, DRAIN, DONE.
- HOLD: cpu_rst=1; hold counter counts RST_CYCLES cycles, then RUN.
- RUN: cpu_rst=0. Each cycle, build record with current cycle_count and push it. Then cycle_count increments.
- Halt: in RUN, instr_e equals any HALT_PATTERNS entry. That cycle's record is pushed, halted is set, and the state goes to DRAIN.
- Timeout: in RUN, max_cycles≠0 and cycle_count ≥ max_cycles. That cycle's record is pushed, timed_out is set, and the state goes to DRAIN.
- Halt and timeout in the same cycle: halted=1, timed_out=0.
- DRAIN: cpu_rst=1 (core frozen). No pushes. cycle_count holds. Go to DONE when the FIFO is empty.
- DONE: cpu_rst=1, done=1. Terminal until rst.
- FIFO is show-ahead: trace_data is valid while trace_valid=1, and a pop occurs on trace_valid&&trace_ready.
- Push when full with no pop in the same cycle: record is discarded and drop_count increments, saturating at 16'hFFFF.
- Push when full with a pop in the same cycle: push is accepted; occupancy unchanged.
- trace_data is stable while trace_valid=1 and trace_ready=0.
- Pointers are log2(FIFO_DEPTH) bits with an occupancy counter 0..FIFO_DEPTH; pointers wrap naturally.
- Reset values: state=HOLD, cpu_rst=1, cycle_count=0, FIFO empty, trace_valid=0, halted=0, timed_out=0, done=0, drop_count=0.
- rst in any state, including mid-RUN or mid-DRAIN: all state and FIFO contents are cleared and the full HOLD sequence restarts.

## Timing
- rst sampled high at edge N, low from edge N+1: cpu_rst stays 1 through edge N+RST_CYCLES and is 0 after edge N+RST_CYCLES+1.
- First RUN cycle record carries cycle=0.
- Push-to-visible latency: a record pushed at edge k into an empty FIFO gives trace_valid=1 after edge k.
- Halt detected in RUN at edge k: halted=1 and cpu_rst=1 after edge k.
- done asserts one cycle after the FIFO becomes empty in DRAIN.
- With max_cycles=M: records for cycles 0..M are produced (M+1 records), then the block stops.

## Test plan
- Reset sequence: RST_CYCLES=5, rst released → cpu_rst high exactly 5 cycles after release edge, then low; cycle_count=0 in first RUN cycle.
- Halt drain: trace_ready=1, instr_e=32'h00000073 on run cycle 10 → 11 records read (cycles 0..10), halted=1, timed_out=0, done=1, drop_count=0.
- Timeout: max_cycles=20, no halt pattern → 21 records, last cycle field=20, timed_out=1, cpu_rst=1 from then on.
- Backpressure: FIFO_DEPTH=8, trace_ready=0, halt at cycle 11 → 8 records held (cycles 0..7), drop_count=4; raise ready → records 0..7 in order, then done=1.
- Simultaneous: max_cycles=5 and instr_e=32'h00100073 at cycle 5 → halted=1, timed_out=0.
- Reset mid-run: assert rst at run cycle 3 with FIFO non-empty → next cycle trace_valid=0, drop_count=0, cpu_rst=1, full HOLD sequence repeats.
